// File: rtl/vector_clk_pkg.sv
// Shared types and constants for the Vector 06C clock-enable generator.
package vector_clk_pkg;

    localparam int unsigned SPEED_W        = 3;
    localparam int unsigned FRAME_LOG2_DEF = 7;

    typedef logic [SPEED_W-1:0] speed_t;

    localparam int unsigned FRAME_LAST         = (1 << FRAME_LOG2_DEF) - 1;
    localparam logic [2:0]  CONTENTION_RELEASE = 3'b100;

    // CPU enable period in clk_sys cycles for speed code k.
    function automatic int unsigned cpu_period(speed_t k, int base_log2);
        return (32'd1 << base_log2) >> k;
    endfunction

endpackage

// File: rtl/clk_mod_pulse.sv
// Modulo-N counter; tick_c is high while the count is 0, pulse is the registered copy.
module clk_mod_pulse #(
    parameter int unsigned N    = 2,
    parameter int unsigned INIT = 0
) (
    input  logic clk_sys,
    input  logic reset_n,
    output logic pulse,
    output logic tick_c
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == '0);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= CNT_W'(INIT);
            pulse <= 1'b0;
        end else begin
            pulse <= tick_c;
            cnt   <= (cnt == CNT_W'(N - 1)) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vector_cpu_clkgen.sv
// Vector 06C clock-enable generator: CPU two-phase enables, pixel, PSG and PIT clocks.
// Wait-state insertion is built only when VECTOR_CLKGEN_CONTENTION_EN is defined.
module vector_cpu_clkgen
    import vector_clk_pkg::*;
#(
    parameter int unsigned FRAME_LOG2 = FRAME_LOG2_DEF,
    parameter int unsigned BASE_LOG2  = 5,
    parameter int unsigned N_SPEEDS   = 4,
    parameter int unsigned PSG_DIV    = 55,
    parameter int unsigned PIT_HALF   = 32
) (
    input  logic   clk_sys,
    input  logic   reset_n,
    input  speed_t speed,
    input  logic   pause,
    input  logic   cpu_sync,
    input  logic   cpu_mreq,
    output logic   ce_f1,
    output logic   ce_f2,
    output logic   ce_12mp,
    output logic   ce_12mn,
    output logic   ce_psg,
    output logic   clk_pit,
    output logic   cpu_ready,
    output speed_t speed_cur,
    output logic   paused,
    output logic   frame_start
);

    logic [FRAME_LOG2-1:0] div;
    logic                  frame_end_c;
    speed_t                speed_req_c;
    int unsigned           period_c;
    logic [FRAME_LOG2-1:0] phase_mask_c;
    logic [FRAME_LOG2-1:0] phase_half_c;
    logic                  f1_hit_c;
    logic                  f2_hit_c;
    logic                  ready_nxt_c;
    logic                  pit_tick_c;
    logic                  unused_psg_tick;
    logic                  unused_pit_pulse;

    assign frame_end_c = (div == '1);

    // Out-of-range speed codes clamp to the fastest grade.
    assign speed_req_c = (32'(speed) >= N_SPEEDS) ? SPEED_W'(N_SPEEDS - 1) : speed;

    assign period_c     = cpu_period(speed_cur, int'(BASE_LOG2));
    assign phase_mask_c = FRAME_LOG2'(period_c - 1);
    assign phase_half_c = FRAME_LOG2'(period_c >> 1);
    assign f1_hit_c     = ((div & phase_mask_c) == '0);
    assign f2_hit_c     = ((div & phase_mask_c) == phase_half_c);

`ifdef VECTOR_CLKGEN_CONTENTION_EN
    // Release window has priority over a new drop; a speed change always frees the CPU.
    always_comb begin
        ready_nxt_c = cpu_ready;
        if (frame_end_c && (speed_req_c != speed_cur)) begin
            ready_nxt_c = 1'b1;
        end else if (speed_cur != '0) begin
            ready_nxt_c = 1'b1;
        end else if (div[6:4] == CONTENTION_RELEASE) begin
            ready_nxt_c = 1'b1;
        end else if ((div[4:2] == 3'b000) && cpu_sync && cpu_mreq) begin
            ready_nxt_c = 1'b0;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = cpu_sync ^ cpu_mreq;

    always_comb begin
        ready_nxt_c = 1'b1;
    end
`endif

    clk_mod_pulse #(
        .N    (PSG_DIV),
        .INIT (0)
    ) u_psg_div (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .pulse   (ce_psg),
        .tick_c  (unused_psg_tick)
    );

    // Starting one count in puts the first PIT rising edge a full half-period after reset.
    clk_mod_pulse #(
        .N    (PIT_HALF),
        .INIT (1 % PIT_HALF)
    ) u_pit_div (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .pulse   (unused_pit_pulse),
        .tick_c  (pit_tick_c)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div         <= '0;
            speed_cur   <= '0;
            paused      <= 1'b0;
            cpu_ready   <= 1'b1;
            ce_f1       <= 1'b0;
            ce_f2       <= 1'b0;
            ce_12mp     <= 1'b0;
            ce_12mn     <= 1'b0;
            clk_pit     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div + FRAME_LOG2'(1);
            ce_f1       <= f1_hit_c && !paused;
            ce_f2       <= f2_hit_c && !paused;
            ce_12mp     <= (div[2:0] == 3'd0);
            ce_12mn     <= (div[2:0] == 3'd4);
            frame_start <= (div == '0);
            clk_pit     <= clk_pit ^ pit_tick_c;
            cpu_ready   <= ready_nxt_c;
            // Speed and pause requests are sampled only at the frame boundary.
            if (frame_end_c) begin
                speed_cur <= speed_req_c;
                paused    <= pause;
            end
        end
    end

endmodule

// File: tb/tb_vector_cpu_clkgen.sv
// Directed bench for vector_cpu_clkgen; expected values come from a per-frame speed/pause table.
`timescale 1ns/1ps
module tb_vector_cpu_clkgen;
    import vector_clk_pkg::*;

    logic   clk_sys = 1'b0;
    logic   reset_n;
    speed_t speed;
    logic   pause;
    logic   cpu_sync;
    logic   cpu_mreq;
    logic   ce_f1, ce_f2, ce_12mp, ce_12mn, ce_psg, clk_pit;
    logic   cpu_ready, paused, frame_start;
    speed_t speed_cur;

    int n_cmp = 0;
    int n_bad = 0;
    int fr_speed [10];
    int fr_pause [10];
    int cont_frame;

    vector_cpu_clkgen dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .speed       (speed),
        .pause       (pause),
        .cpu_sync    (cpu_sync),
        .cpu_mreq    (cpu_mreq),
        .ce_f1       (ce_f1),
        .ce_f2       (ce_f2),
        .ce_12mp     (ce_12mp),
        .ce_12mn     (ce_12mn),
        .ce_psg      (ce_psg),
        .clk_pit     (clk_pit),
        .cpu_ready   (cpu_ready),
        .speed_cur   (speed_cur),
        .paused      (paused),
        .frame_start (frame_start)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag, input int cyc);
        check({tag, "_ce_f1"},   cyc, 32'(ce_f1),       32'd0);
        check({tag, "_ce_f2"},   cyc, 32'(ce_f2),       32'd0);
        check({tag, "_ce_12mp"}, cyc, 32'(ce_12mp),     32'd0);
        check({tag, "_ce_12mn"}, cyc, 32'(ce_12mn),     32'd0);
        check({tag, "_ce_psg"},  cyc, 32'(ce_psg),      32'd0);
        check({tag, "_clk_pit"}, cyc, 32'(clk_pit),     32'd0);
        check({tag, "_ready"},   cyc, 32'(cpu_ready),   32'd1);
        check({tag, "_speed"},   cyc, 32'(speed_cur),   32'd0);
        check({tag, "_paused"},  cyc, 32'(paused),      32'd0);
        check({tag, "_fstart"},  cyc, 32'(frame_start), 32'd0);
    endtask

    // c = posedges since reset release; outputs reflect the decode of div = (c-1) mod 128.
    task automatic check_cycle(input int c);
        int fd;
        int d;
        int fc;
        int p;
        bit rdy;
        fd = (c - 1) / 128;
        d  = (c - 1) % 128;
        fc = c / 128;
        p  = 32 >> fr_speed[fd];
        rdy = 1'b1;
`ifdef VECTOR_CLKGEN_CONTENTION_EN
        if (fd == cont_frame && d >= 33 && d <= 63) rdy = 1'b0;
`endif
        check("ce_f1",   c, 32'(ce_f1),       32'(fr_pause[fd] == 0 && d % p == 0));
        check("ce_f2",   c, 32'(ce_f2),       32'(fr_pause[fd] == 0 && d % p == p / 2));
        check("ce_12mp", c, 32'(ce_12mp),     32'(d % 8 == 0));
        check("ce_12mn", c, 32'(ce_12mn),     32'(d % 8 == 4));
        check("fstart",  c, 32'(frame_start), 32'(d == 0));
        check("ce_psg",  c, 32'(ce_psg),      32'((c - 1) % 55 == 0));
        check("clk_pit", c, 32'(clk_pit),     32'((c / 32) % 2));
        check("speed",   c, 32'(speed_cur),   32'(fr_speed[fc]));
        check("paused",  c, 32'(paused),      32'(fr_pause[fc]));
        check("ready",   c, 32'(cpu_ready),   32'(rdy));
    endtask

    // Requests are driven just after the edge that leaves div == c mod 128.
    task automatic drive_inputs(input int c);
        cpu_sync = 1'b0;
        cpu_mreq = 1'b0;
        case (c)
            296:                 speed = 3'd1;
            404:                 speed = 3'd7;
            650:                 begin speed = 3'd0; pause = 1'b1; end
            828:                 pause = 1'b0;
            385, 912, 966, 1057: begin cpu_sync = 1'b1; cpu_mreq = 1'b1; end
            default:             ;
        endcase
    endtask

    initial begin
        reset_n  = 1'b0;
        speed    = 3'd0;
        pause    = 1'b0;
        cpu_sync = 1'b0;
        cpu_mreq = 1'b0;
        fr_speed = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 0};
        fr_pause = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        cont_frame = 8;

        repeat (3) @(negedge clk_sys);
        check_reset("por", 0);
        reset_n = 1'b1;
        check("rel_ce_f1", 0, 32'(ce_f1), 32'd0);

        for (int c = 1; c <= 1074; c++) begin
            @(negedge clk_sys);
            check_cycle(c);
            drive_inputs(c);
        end

        // Asynchronous reset in the middle of a wait state.
        reset_n = 1'b0;
        #1;
        check_reset("async", 1074);
        repeat (2) @(negedge clk_sys);
        check_reset("hold", 0);

        foreach (fr_speed[i]) begin
            fr_speed[i] = 0;
            fr_pause[i] = 0;
        end
        cont_frame = -1;
        reset_n = 1'b1;
        check("rel2_ce_f1", 0, 32'(ce_f1), 32'd0);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk_sys);
            check_cycle(c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
